// File: rtl/imm_gen_pipe_pkg.sv
// Shared definitions for the pipelined immediate generator: format codes,
// RV32 opcodes, buffer states and the opcode-to-format decoder.
package imm_pkg;

    typedef enum logic [2:0] {
        FMT_I   = 3'b000,
        FMT_S   = 3'b001,
        FMT_B   = 3'b010,
        FMT_J   = 3'b011,
        FMT_U   = 3'b100,
        FMT_Z   = 3'b101,
        FMT_RSV = 3'b110,
        FMT_ILL = 3'b111
    } imm_fmt_e;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'b00,
        BUF_ONE   = 2'b01,
        BUF_TWO   = 2'b10
    } buf_state_e;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // SYSTEM splits on funct3[2]: the immediate CSR forms carry a zimm.
    function automatic imm_fmt_e decode_fmt(input logic [31:0] instr);
        imm_fmt_e fmt;
        casez (instr)
            {25'b?, OP_IMM}, {25'b?, OP_LOAD}, {25'b?, OP_JALR}: fmt = FMT_I;
            {25'b?, OP_STORE}:                                  fmt = FMT_S;
            {25'b?, OP_BRANCH}:                                 fmt = FMT_B;
            {25'b?, OP_JAL}:                                    fmt = FMT_J;
            {25'b?, OP_LUI}, {25'b?, OP_AUIPC}:                 fmt = FMT_U;
            {17'b?, 1'b1, 7'b?, OP_SYSTEM}:                     fmt = FMT_Z;
            {17'b?, 1'b0, 7'b?, OP_SYSTEM}:                     fmt = FMT_I;
            default:                                            fmt = FMT_ILL;
        endcase
        return fmt;
    endfunction

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Upstream and downstream handshake bundle of the immediate generator.
interface imm_gen_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [2:0]       in_imm_src;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [2:0]       out_type;
    logic             out_illegal;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_instr, in_imm_src, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_type, out_illegal, out_tag
    );

    modport slave (
        input  in_valid, in_instr, in_imm_src, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_type, out_illegal, out_tag
    );
endinterface

// File: rtl/imm_gen_pipe_extend.sv
// Combinational immediate extender: builds a 64-bit value and keeps the low
// XLEN bits, so every format sign-extends from its own top bit.
module imm_extend_comb
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:7]     instr,
    input  logic [2:0]      fmt,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);

    logic [63:0] wide;

    always_comb begin
        wide    = '0;
        illegal = 1'b0;
        case (fmt)
            FMT_I: wide = {{52{instr[31]}}, instr[31:20]};
            FMT_S: wide = {{52{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B: wide = {{52{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_J: wide = {{44{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            FMT_U: wide = {{32{instr[31]}}, instr[31:12], 12'b0};
            FMT_Z: wide = {59'b0, instr[19:15]};
            default: begin
                wide    = '0;
                illegal = 1'b1;
            end
        endcase
    end

    assign imm = wide[XLEN-1:0];

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with a two-entry skid buffer: main holds the
// presented result, skid absorbs one extra accept while downstream stalls.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int TAG_W       = 32,
    parameter bit AUTO_DECODE = 1'b1
) (
    input logic         clk,
    input logic         rst,
    input logic         flush,
    imm_gen_pipe_if.slave bus
);

    logic [2:0]       fmt_sel;
    logic [XLEN-1:0]  new_imm;
    logic             new_ill;

    buf_state_e       state_reg, state_next;
    logic             in_ready_reg;
    logic [XLEN-1:0]  main_imm_reg, skid_imm_reg;
    logic [2:0]       main_type_reg, skid_type_reg;
    logic             main_ill_reg, skid_ill_reg;
    logic [TAG_W-1:0] main_tag_reg, skid_tag_reg;

    logic             accept, drain;
    logic             load_main, load_skid, move_skid;

    generate
        if (AUTO_DECODE) begin : g_auto
            assign fmt_sel = decode_fmt(bus.in_instr);
        end else begin : g_explicit
            assign fmt_sel = bus.in_imm_src;
        end
    endgenerate

    imm_extend_comb #(.XLEN(XLEN)) u_extend (
        .instr   (bus.in_instr[31:7]),
        .fmt     (fmt_sel),
        .imm     (new_imm),
        .illegal (new_ill)
    );

    // in_ready_reg already encodes state != TWO; flush overrides any accept.
    assign accept = bus.in_valid & in_ready_reg & ~flush;
    assign drain  = bus.out_ready & (state_reg != BUF_EMPTY);

    always_comb begin
        state_next = state_reg;
        load_main  = 1'b0;
        load_skid  = 1'b0;
        move_skid  = 1'b0;
        case (state_reg)
            BUF_EMPTY: begin
                if (accept) begin
                    state_next = BUF_ONE;
                    load_main  = 1'b1;
                end
            end
            BUF_ONE: begin
                if (accept && drain) begin
                    load_main = 1'b1;
                end else if (drain) begin
                    state_next = BUF_EMPTY;
                end else if (accept) begin
                    state_next = BUF_TWO;
                    load_skid  = 1'b1;
                end
            end
            BUF_TWO: begin
                if (drain) begin
                    state_next = BUF_ONE;
                    move_skid  = 1'b1;
                end
            end
            default: state_next = BUF_EMPTY;
        endcase
        if (flush) begin
            state_next = BUF_EMPTY;
            move_skid  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= BUF_EMPTY;
            in_ready_reg  <= 1'b1;
            main_imm_reg  <= '0;
            main_type_reg <= '0;
            main_ill_reg  <= 1'b0;
            main_tag_reg  <= '0;
            skid_imm_reg  <= '0;
            skid_type_reg <= '0;
            skid_ill_reg  <= 1'b0;
            skid_tag_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            in_ready_reg <= (state_next != BUF_TWO);
            if (load_main) begin
                main_imm_reg  <= new_imm;
                main_type_reg <= fmt_sel;
                main_ill_reg  <= new_ill;
                main_tag_reg  <= bus.in_tag;
            end else if (move_skid) begin
                main_imm_reg  <= skid_imm_reg;
                main_type_reg <= skid_type_reg;
                main_ill_reg  <= skid_ill_reg;
                main_tag_reg  <= skid_tag_reg;
            end
            if (load_skid) begin
                skid_imm_reg  <= new_imm;
                skid_type_reg <= fmt_sel;
                skid_ill_reg  <= new_ill;
                skid_tag_reg  <= bus.in_tag;
            end
        end
    end

    assign bus.in_ready    = in_ready_reg;
    assign bus.out_valid   = (state_reg != BUF_EMPTY);
    assign bus.out_imm     = main_imm_reg;
    assign bus.out_type    = main_type_reg;
    assign bus.out_illegal = main_ill_reg;
    assign bus.out_tag     = main_tag_reg;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for two generator instances: 32-bit auto-decode (A) and
// 64-bit explicit-format (B), each checked against an arithmetic model.
module tb_imm_gen_pipe;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic flush_a = 1'b0;
    logic flush_b = 1'b0;

    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(32), .TAG_W(32)) ba ();
    imm_gen_pipe_if #(.XLEN(64), .TAG_W(16)) bb ();

    imm_gen_pipe #(.XLEN(32), .TAG_W(32), .AUTO_DECODE(1'b1)) dut_a (
        .clk(clk), .rst(rst), .flush(flush_a), .bus(ba)
    );
    imm_gen_pipe #(.XLEN(64), .TAG_W(16), .AUTO_DECODE(1'b0)) dut_b (
        .clk(clk), .rst(rst), .flush(flush_b), .bus(bb)
    );

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  typ;
        logic        ill;
        logic [31:0] tag;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Reference: format from the opcode table, value via signed arithmetic.
    function automatic logic [2:0] ref_fmt(logic [31:0] instr);
        case (instr[6:0])
            7'h13, 7'h03, 7'h67: return 3'd0;
            7'h23:               return 3'd1;
            7'h63:               return 3'd2;
            7'h6F:               return 3'd3;
            7'h37, 7'h17:        return 3'd4;
            7'h73:               return instr[14] ? 3'd5 : 3'd0;
            default:             return 3'd7;
        endcase
    endfunction

    function automatic logic [63:0] ref_imm(logic [31:0] instr, logic [2:0] fmt, int xlen);
        longint v;
        case (fmt)
            3'd0: v = longint'($signed(instr[31:20]));
            3'd1: v = longint'($signed({instr[31:25], instr[11:7]}));
            3'd2: v = longint'($signed({instr[31], instr[7], instr[30:25], instr[11:8]})) * 2;
            3'd3: v = longint'($signed({instr[31], instr[19:12], instr[20], instr[30:21]})) * 2;
            3'd4: v = longint'($signed(instr[31:12])) * 4096;
            3'd5: v = longint'(instr[19:15]);
            default: v = 0;
        endcase
        if (xlen == 32) return {32'b0, v[31:0]};
        return v;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [0:8] = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17, 7'h73};
        int k = $urandom_range(0, 9);
        logic [6:0] op = (k == 9) ? 7'($urandom) : ops[k];
        return {25'($urandom), op};
    endfunction

    // One cycle of stimulus on A; model occupancy decides in_ready/accept.
    task automatic cyc_a(logic v, logic [31:0] instr, logic [31:0] tag, logic ordy, logic fl);
        logic [2:0] f;
        @(negedge clk);
        ba.in_valid   = v;
        ba.in_instr   = instr;
        ba.in_tag     = tag;
        ba.in_imm_src = 3'($urandom);
        ba.out_ready  = ordy;
        flush_a       = fl;
        #1;
        check("a_in_ready", ba.in_ready, qa.size() < 2);
        check("a_out_valid", ba.out_valid, qa.size() > 0);
        if (v && qa.size() < 2 && !fl) begin
            f = ref_fmt(instr);
            qa.push_back('{ref_imm(instr, f, 32), f, f >= 3'd6, tag});
        end
    endtask

    task automatic cyc_b(logic v, logic [31:0] instr, logic [2:0] src, logic [15:0] tag,
                         logic ordy, logic fl);
        @(negedge clk);
        bb.in_valid   = v;
        bb.in_instr   = instr;
        bb.in_imm_src = src;
        bb.in_tag     = tag;
        bb.out_ready  = ordy;
        flush_b       = fl;
        #1;
        check("b_in_ready", bb.in_ready, qb.size() < 2);
        check("b_out_valid", bb.out_valid, qb.size() > 0);
        if (v && qb.size() < 2 && !fl)
            qb.push_back('{ref_imm(instr, src, 64), src, src >= 3'd6, {16'b0, tag}});
    endtask

    always begin
        @(negedge clk);
        #2;
        if (!rst && ba.out_valid && ba.out_ready) begin
            if (qa.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL a_unexpected: got tag %h expected no output", ba.out_tag);
            end else begin
                ea = qa.pop_front();
                $display("A out tag=%h imm=%h type=%0d ill=%0b", ba.out_tag, ba.out_imm,
                         ba.out_type, ba.out_illegal);
                check("a_imm", {32'b0, ba.out_imm}, ea.imm);
                check("a_type", ba.out_type, ea.typ);
                check("a_ill", ba.out_illegal, ea.ill);
                check("a_tag", ba.out_tag, ea.tag);
            end
        end
        if (flush_a) qa.delete();
    end

    always begin
        @(negedge clk);
        #2;
        if (!rst && bb.out_valid && bb.out_ready) begin
            if (qb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL b_unexpected: got tag %h expected no output", bb.out_tag);
            end else begin
                eb = qb.pop_front();
                $display("B out tag=%h imm=%h type=%0d ill=%0b", bb.out_tag, bb.out_imm,
                         bb.out_type, bb.out_illegal);
                check("b_imm", bb.out_imm, eb.imm);
                check("b_type", bb.out_type, eb.typ);
                check("b_ill", bb.out_illegal, eb.ill);
                check("b_tag", {16'b0, bb.out_tag}, eb.tag);
            end
        end
        if (flush_b) qb.delete();
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        ba.in_valid = 0; ba.in_instr = 0; ba.in_imm_src = 0; ba.in_tag = 0; ba.out_ready = 0;
        bb.in_valid = 0; bb.in_instr = 0; bb.in_imm_src = 0; bb.in_tag = 0; bb.out_ready = 0;
        #1 rst = 1'b1;
        #11;
        check("rst_a_in_ready", ba.in_ready, 1);
        check("rst_a_out_valid", ba.out_valid, 0);
        check("rst_a_out_imm", ba.out_imm, 0);
        check("rst_a_out_type", ba.out_type, 0);
        check("rst_a_out_ill", ba.out_illegal, 0);
        check("rst_a_out_tag", ba.out_tag, 0);
        check("rst_b_in_ready", bb.in_ready, 1);
        check("rst_b_out_valid", bb.out_valid, 0);
        check("rst_b_out_imm", bb.out_imm, 0);
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back decode at full throughput.
        cyc_a(1, 32'hFFF00093, 32'h100, 1, 0);
        cyc_a(1, 32'hFE112E23, 32'h101, 1, 0);
        cyc_a(1, 32'hFE000CE3, 32'h102, 1, 0);
        cyc_a(1, 32'h0010006F, 32'h103, 1, 0);
        repeat (3) cyc_a(0, 0, 0, 1, 0);

        // 64-bit U and Z formats, explicit format select.
        cyc_b(1, 32'h123452B7, 3'd4, 16'h200, 1, 0);
        cyc_b(1, 32'h800002B7, 3'd4, 16'h201, 1, 0);
        cyc_b(1, 32'h0002D073, 3'd5, 16'h202, 1, 0);
        cyc_b(1, 32'h12345678, 3'd6, 16'h203, 1, 0);
        cyc_b(1, 32'h87654321, 3'd7, 16'h204, 1, 0);
        repeat (3) cyc_b(0, 0, 0, 0, 1, 0);

        // Backpressure: two held, third refused, then in-order drain.
        cyc_a(1, 32'h00500093, 32'h300, 0, 0);
        cyc_a(1, 32'h80000137, 32'h301, 0, 0);
        cyc_a(1, 32'h00A02023, 32'h302, 0, 0);
        cyc_a(0, 0, 0, 0, 0);
        repeat (4) cyc_a(0, 0, 0, 1, 0);

        // Illegal opcode on the auto-decode instance.
        cyc_a(1, 32'hABCDE07F, 32'h400, 1, 0);
        repeat (2) cyc_a(0, 0, 0, 1, 0);

        // Flush while full with a new offer: everything dropped.
        cyc_a(1, 32'h00100093, 32'h500, 0, 0);
        cyc_a(1, 32'h00200093, 32'h501, 0, 0);
        cyc_a(1, 32'h00300093, 32'h502, 0, 1);
        repeat (3) cyc_a(0, 0, 0, 1, 0);

        // Asynchronous reset while holding one entry.
        cyc_a(1, 32'h7FF00093, 32'h600, 0, 0);
        @(negedge clk);
        ba.in_valid = 0;
        #3 rst = 1'b1;
        #1;
        check("arst_a_out_valid", ba.out_valid, 0);
        check("arst_a_in_ready", ba.in_ready, 1);
        qa.delete();
        qb.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_a_out_imm", ba.out_imm, 0);
        check("post_rst_a_out_tag", ba.out_tag, 0);
        check("post_rst_a_out_type", ba.out_type, 0);
        check("post_rst_a_out_ill", ba.out_illegal, 0);
        check("post_rst_a_out_valid", ba.out_valid, 0);
        check("post_rst_a_in_ready", ba.in_ready, 1);

        for (int i = 0; i < 300; i++)
            cyc_a($urandom_range(0, 3) != 0, rand_instr(), $urandom,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);
        repeat (4) cyc_a(0, 0, 0, 1, 0);

        for (int i = 0; i < 300; i++)
            cyc_b($urandom_range(0, 3) != 0, $urandom, 3'($urandom_range(0, 7)), 16'($urandom),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);
        repeat (4) cyc_b(0, 0, 0, 0, 1, 0);

        check("a_drained", qa.size(), 0);
        check("b_drained", qb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Registered, handshaked immediate generator for the pipelined RISC-V core.
- Sits between the IF/ID register and the ID/EX register.
- Generalises the single-cycle extender in four ways:
  - XLEN-parametric output width.
  - U-type and CSR-zimm formats.
  - Optional opcode auto-decode.
  - Valid/ready flow control through a 2-entry skid buffer with flush.

Parameters:
- XLEN, 32, output width; legal values 32 or 64.
- TAG_W, 32, width of the sideband tag carried alongside each instruction (PC, rd, ...).
- AUTO_DECODE, 1:
  - 1 = format derived from instr[6:0].
  - 0 = format taken from in_imm_src.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous pipeline flush.
- in_valid  in  1  upstream has an instruction.
- in_ready  out  1  block can accept; registered.
- in_instr  in  32  raw instruction.
- in_imm_src  in  3  explicit format; ignored when AUTO_DECODE=1.
- in_tag  in  TAG_W  sideband, passed through unchanged.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts.
- out_imm  out  XLEN  extended immediate.
- out_type  out  3  resolved format code.
- out_illegal  out  1  unsupported format/opcode.
- out_tag  out  TAG_W  tag of the presented result.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high on rst.
- Reset values: out_valid=0, in_ready=1, out_imm=0, out_type=0, out_illegal=0, out_tag=0; both buffer entries invalid.
- Format codes (shared package):
  - 000 I: sext(instr[31:20]).
  - 001 S: sext({instr[31:25], instr[11:7]}).
  - 010 B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - 011 J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - 100 U: sext({instr[31:12], 12'b0}); at XLEN=64 bits 63:32 replicate instr[31].
  - 101 Z: zero-extended instr[19:15].
  - 110/111: out_imm=0, out_illegal=1.
- Sign extension is always from the format's top bit to XLEN.
- Auto-decode table (instr[6:0]):
  - 0010011, 0000011, 1100111 → I.
  - 0100011 → S.
  - 1100011 → B.
  - 1101111 → J.
  - 0110111, 0010111 → U.
  - 1110011: instr[14]=1 → Z, else I.
  - Any other opcode → 111 (illegal).
- Latency and throughput:
  - Latency exactly 1 cycle from an accepted input to out_valid, with no stall.
  - Full throughput: one result per cycle when out_ready is held high.
- Handshake:
  - Transfer in happens on in_valid & in_ready.
  - Transfer out happens on out_valid & out_ready.
  - Once asserted, out_valid and the out_* payload stay stable until accepted.
- Buffer FSM (main = presented entry, skid = overflow entry):
  - EMPTY:
    - Accept → ONE.
  - ONE:
    - Accept and drain in the same cycle → ONE with the new data.
    - Drain only → EMPTY.
    - Accept without drain → TWO (new data into skid).
    - in_ready stays 1.
  - TWO:
    - in_ready=0.
    - Drain → ONE; skid moves to main in that cycle.
    - No input is accepted in TWO.
- in_ready is driven from a flop equal to (next state != TWO); there is no combinational path from out_ready.
- Flush: next cycle state=EMPTY, out_valid=0, in_ready=1. An input offered in the flush cycle is dropped; flush dominates accept.
- Reset mid-transfer: all held entries are discarded immediately (asynchronous).
- Payload is computed combinationally from in_* and captured in the entry registers. No combinational in→out path.

Decomposition:
- Package imm_pkg:
  - imm_fmt_e format codes.
  - Opcode localparams.
  - Function decode_fmt(instr) returning the format code.
- Sub-module imm_extend_comb: purely combinational (instr, fmt) → {imm, illegal}, parameterised on XLEN.
- Top imm_gen_pipe holds the skid FSM and entry registers.

Test Plan:
1. AUTO_DECODE=1, XLEN=32, out_ready=1; instructions 0xFFF00093 (addi -1), 0xFE112E23 (sw -4), 0xFE000CE3 (beq -8), 0x0010006F (jal +2048) on consecutive cycles → out_imm 0xFFFFFFFF, 0xFFFFFFFC, 0xFFFFFFF8, 0x00000800, each one cycle after its input, no bubbles; out_type 0,1,2,3.
2. XLEN=64; 0x123452B7 then 0x800002B7 (lui) → 0x0000000012345000, then 0xFFFFFFFF80000000; 0x0002D073 (csrrwi zimm=5) → 0x5, out_type=101.
3. Backpressure: out_ready=0, three back-to-back valid inputs:
   - First two are held; in_ready drops on the cycle after the second accept; the third is not accepted.
   - Raise out_ready: results drain in order with tags intact, in_ready returns to 1 after the first drain.
4. Illegal handling: opcode 0x7F with AUTO_DECODE=1, and in_imm_src=110 with AUTO_DECODE=0 → out_illegal=1, out_imm=0, out_type=111 for the opcode case and 110 for the explicit case.
5. Flush while in TWO with in_valid=1 → next cycle out_valid=0, in_ready=1, flushed input never appears at the output.
6. rst asserted mid-cycle while in ONE → out_valid falls immediately (no clock edge needed); after release in_ready=1 and all outputs 0.
